simple_bit_pack_stream: RTL and testbench
=========================================

// Module: simple_bit_pack_stream
// PURPOSE
//  Streaming SimpleBitPack encoder for ML-DSA: inverse of the SimpleBitUnpack decoder.
//  - Accepts 256 coefficients of W = bitlen(B) bits, one per valid/ready handshake.
//  - Emits the packed 32*W-byte string LSB-first, one byte per valid/ready handshake.
//  - Byte j of the output equals bits [8j+7:8j] of the flat vector, where coeff i occupies bits [i*W +: W].
//  - Sits between the polynomial arithmetic datapath and the byte-oriented public-key/signature encoder.
// PARAMETERS
//  B  1023  coefficient upper bound; W = (B==0) ? 1 : $clog2(B+1); total bytes NB = 32*W
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  asynchronous, active-low reset
//  coeff_valid in   1  coeff holds a valid coefficient
//  coeff_ready out  1  block accepts coeff this cycle
//  coeff       in   W  coefficient value, nominally 0..B
//  byte_valid  out  1  byte_out holds a valid output byte
//  byte_ready  in   1  downstream accepts byte_out this cycle
//  byte_out    out  8  packed output byte
//  byte_last   out  1  byte_out is byte NB-1 of the current polynomial
//  busy        out  1  a polynomial is in progress (state != IDLE)
//  coeff_err   out  1  one-cycle pulse: the last accepted coeff was > B
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, acc=0, acc_cnt=0, coeff_idx=0, byte_idx=0.
//    All outputs are 0 except coeff_ready=1.
//  - Datapath:
//    - acc is a (W+7)-bit shift register; acc_cnt is the number of valid bits in acc.
//    - byte_out = acc[7:0] (registered); byte_valid = (acc_cnt >= 8).
//  - Coefficient accept (coeff_valid & coeff_ready): acc |= coeff << acc_cnt; acc_cnt += W; coeff_idx++.
//  - Byte handshake (byte_valid & byte_ready): acc >>= 8; acc_cnt -= 8; byte_idx++.
//  - coeff_ready = (acc_cnt < 8) && state != DRAIN.
//    - A coefficient accept and a byte handshake are therefore mutually exclusive in a cycle.
//    - byte_out and byte_valid stay stable while byte_ready is low.
//  - Latency: a coefficient accepted at edge t makes its first completed byte visible from t+1.
//  - FSM:
//    - IDLE -> FILL on the first coefficient accept.
//    - FILL -> DRAIN on the accept with coeff_idx==255 (the 256th coefficient).
//    - DRAIN -> IDLE on the handshake of byte_idx==NB-1. Counters return to 0; acc_cnt is 0 by construction.
//  - byte_last = byte_valid && byte_idx == NB-1.
//  - Polynomials are back-to-back: in IDLE the next polynomial's coefficients are accepted immediately.
//  - coeff_err is registered: it pulses the cycle after an accept with coeff > B. The value is still packed (truncated to W bits).
//  - Reset asserted mid-polynomial discards all partial state; no partial bytes are emitted afterwards.
//  - B=0 (W=1): 8 coefficients per byte; NB=32.
// TESTING
//  1. B=1023, coeffs 0..255 ramp, byte_ready=1 -> 320 bytes: 0x00,0x04,0x20,...; byte_last only on byte 319.
//  2. B=1023, coeff0=0x3FF, coeff1=0 -> byte0=0xFF, byte1=0x03; busy=1 from first accept until byte 319 handshake.
//  3. B=0, 256 coeffs all 1 -> 32 bytes of 0xFF; coeff_ready never drops for more than 1 cycle.
//  4. B=1023, byte_ready held low 5 cycles mid-stream -> byte_out/byte_valid stable; coeff_ready=0; no data loss.
//  5. B=6 (W=3), coeff=7 accepted -> coeff_err=1 for exactly 1 cycle; bits packed as 3'b111.
//  6. Reset low at coeff 100, then full polynomial -> outputs match a reference packer with no residue from the aborted frame.

Source files
------------

// File: rtl/simple_bit_pack_stream.sv
// Streaming SimpleBitPack encoder: packs 256 W-bit coefficients LSB-first
// into a 32*W-byte stream, one coefficient in and one byte out per handshake.
module simple_bit_pack_stream #(
  parameter  int unsigned B = 1023,
  localparam int unsigned W = (B == 0) ? 1 : $clog2(B + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         coeff_valid,
  output logic         coeff_ready,
  input  logic [W-1:0] coeff,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic [7:0]   byte_out,
  output logic         byte_last,
  output logic         busy,
  output logic         coeff_err
);

  localparam int unsigned NB  = 32 * W;
  localparam int unsigned AW  = W + 7;
  localparam int unsigned CW  = $clog2(AW + 1);
  localparam int unsigned BIW = $clog2(NB);
  localparam logic [W-1:0]   B_W     = W'(B);
  localparam logic [BIW-1:0] LAST_BI = BIW'(NB - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  acc_cnt_q, acc_cnt_d;
  logic [7:0]     coeff_idx_q, coeff_idx_d;
  logic [BIW-1:0] byte_idx_q, byte_idx_d;
  logic           coeff_err_q, coeff_err_d;
  logic           accept, handshake;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      coeff_idx_q <= '0;
      byte_idx_q  <= '0;
      coeff_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      coeff_idx_q <= coeff_idx_d;
      byte_idx_q  <= byte_idx_d;
      coeff_err_q <= coeff_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    coeff_idx_d = coeff_idx_q;
    byte_idx_d  = byte_idx_q;

    // Ready only while fewer than 8 bits are buffered, so accept and byte
    // handshake can never coincide and the accumulator never overflows.
    coeff_ready = (acc_cnt_q < CW'(8)) && (state_q != DRAIN);
    byte_valid  = (acc_cnt_q >= CW'(8));
    accept      = coeff_valid && coeff_ready;
    handshake   = byte_valid && byte_ready;
    coeff_err_d = accept && (coeff > B_W);

    if (accept) begin
      acc_d       = acc_q | (AW'(coeff) << acc_cnt_q);
      acc_cnt_d   = acc_cnt_q + CW'(W);
      coeff_idx_d = coeff_idx_q + 8'd1;
      case (state_q)
        IDLE:    state_d = FILL;
        FILL:    if (coeff_idx_q == 8'd255) state_d = DRAIN;
        default: state_d = state_q;
      endcase
    end else if (handshake) begin
      acc_d     = acc_q >> 8;
      acc_cnt_d = acc_cnt_q - CW'(8);
      if (byte_idx_q == LAST_BI) begin
        byte_idx_d  = '0;
        coeff_idx_d = '0;
        state_d     = IDLE;
      end else begin
        byte_idx_d = byte_idx_q + BIW'(1);
      end
    end
  end

  assign byte_out  = acc_q[7:0];
  assign byte_last = byte_valid && (byte_idx_q == LAST_BI);
  assign busy      = (state_q != IDLE);
  assign coeff_err = coeff_err_q;

endmodule

// File: tb/tb_simple_bit_pack_stream.sv
// Randomized bench for simple_bit_pack_stream: three instances (W=10, 3, 1)
// checked cycle by cycle against a bit-array packing model.
module tb_simple_bit_pack_stream;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cv = 1'b0;
  logic br = 1'b0;
  logic [9:0] cin = '0;
  int sel = 0;

  logic cv0, cv1, cv2;
  logic cr0, cr1, cr2, bv0, bv1, bv2, bl0, bl1, bl2;
  logic busy0, busy1, busy2, er0, er1, er2;
  logic [7:0] bo0, bo1, bo2;
  logic cr_m, bv_m, bl_m, busy_m, er_m;
  logic [7:0] bo_m;

  int errors = 0;
  int checks = 0;
  int cq[256];
  logic [7:0] expq[$];
  logic [7:0] cap[$];
  int max_low;

  always #5 clk = ~clk;

  assign cv0 = cv && (sel == 0);
  assign cv1 = cv && (sel == 1);
  assign cv2 = cv && (sel == 2);

  simple_bit_pack_stream #(.B(1023)) u_w10 (
    .clk(clk), .reset(reset), .coeff_valid(cv0), .coeff_ready(cr0), .coeff(cin),
    .byte_valid(bv0), .byte_ready(br), .byte_out(bo0), .byte_last(bl0),
    .busy(busy0), .coeff_err(er0));

  simple_bit_pack_stream #(.B(6)) u_w3 (
    .clk(clk), .reset(reset), .coeff_valid(cv1), .coeff_ready(cr1), .coeff(cin[2:0]),
    .byte_valid(bv1), .byte_ready(br), .byte_out(bo1), .byte_last(bl1),
    .busy(busy1), .coeff_err(er1));

  simple_bit_pack_stream #(.B(0)) u_w1 (
    .clk(clk), .reset(reset), .coeff_valid(cv2), .coeff_ready(cr2), .coeff(cin[0:0]),
    .byte_valid(bv2), .byte_ready(br), .byte_out(bo2), .byte_last(bl2),
    .busy(busy2), .coeff_err(er2));

  always_comb begin
    cr_m = cr0; bv_m = bv0; bl_m = bl0; busy_m = busy0; er_m = er0; bo_m = bo0;
    if (sel == 1) begin
      cr_m = cr1; bv_m = bv1; bl_m = bl1; busy_m = busy1; er_m = er1; bo_m = bo1;
    end else if (sel == 2) begin
      cr_m = cr2; bv_m = bv2; bl_m = bl2; busy_m = busy2; er_m = er2; bo_m = bo2;
    end
  end

  function automatic int w_of();
    return (sel == 0) ? 10 : (sel == 1) ? 3 : 1;
  endfunction

  function automatic int b_of();
    return (sel == 0) ? 1023 : (sel == 1) ? 6 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // Output byte j collects flat bits 8j..8j+7, flat bit p being bit p%W of coeff p/W.
  task automatic build_expected(input int w);
    expq.delete();
    for (int j = 0; j < 32 * w; j++) begin
      logic [7:0] b;
      b = '0;
      for (int k = 0; k < 8; k++) begin
        int p;
        p = 8 * j + k;
        b[k] = ((cq[p / w] >> (p % w)) & 1) != 0;
      end
      expq.push_back(b);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) cq[i] = int'($urandom_range((1 << w_of()) - 1, 0));
  endtask

  task automatic run_frame(input int abort_at, input int pv, input int pr, input int hold_at);
    int w, nb, acc, hs, cyc, low_run, hold, bits;
    bit pend_err;
    w = w_of(); nb = 32 * w;
    acc = 0; hs = 0; cyc = 0; low_run = 0; hold = 0; pend_err = 0;
    max_low = 0;
    build_expected(w);
    cap.delete();
    forever begin
      @(negedge clk);
      bits = acc * w - hs * 8;
      check("coeff_ready", cr_m, (bits < 8) && (acc < 256));
      check("byte_valid", bv_m, bits >= 8);
      check("busy", busy_m, acc > 0);
      check("coeff_err", er_m, pend_err);
      if (bits >= 8) begin
        check("byte_out", bo_m, expq[hs]);
        check("byte_last", bl_m, hs == nb - 1);
      end else begin
        check("byte_last_idle", bl_m, 0);
      end
      if (acc < 256 && !cr_m) low_run++; else low_run = 0;
      if (low_run > max_low) max_low = low_run;
      if (abort_at >= 0 && acc == abort_at) begin
        cv = 1'b0; br = 1'b0;
        return;
      end
      if (++cyc > 4000) begin
        check("frame_timeout", 0, 1);
        cv = 1'b0;
        return;
      end
      cv  = (acc < 256) && ($urandom_range(99, 0) < pv);
      cin = (acc < 256) ? 10'(cq[acc]) : '0;
      if (hold_at >= 0 && hs == hold_at && bits >= 8 && hold < 5) begin
        br = 1'b0;
        hold++;
      end else begin
        br = $urandom_range(99, 0) < pr;
      end
      pend_err = cv && cr_m && (int'(cin) > b_of());
      if (cv && cr_m) acc++;
      if (br && bv_m) begin
        cap.push_back(bo_m);
        hs++;
        if (hs == nb) begin
          cv = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_coeff_ready", cr_m, 1);
    check("rst_byte_valid", bv_m, 0);
    check("rst_byte_out", bo_m, 0);
    check("rst_byte_last", bl_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_coeff_err", er_m, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    sel = 0;
    pulse_reset();

    // Ramp 0..255, full throughput.
    for (int i = 0; i < 256; i++) cq[i] = i;
    run_frame(-1, 100, 100, -1);
    check("ramp_len", cap.size(), 320);
    check("ramp_b0", cap[0], 8'h00);
    check("ramp_b1", cap[1], 8'h04);
    check("ramp_b2", cap[2], 8'h20);

    // Max coefficient then zero, back-to-back with the previous frame.
    fill_random();
    cq[0] = 1023; cq[1] = 0;
    run_frame(-1, 100, 100, -1);
    check("max_b0", cap[0], 8'hFF);
    check("max_b1", cap[1], 8'h03);

    // W=1, all ones.
    sel = 2;
    for (int i = 0; i < 256; i++) cq[i] = 1;
    run_frame(-1, 100, 100, -1);
    check("ones_len", cap.size(), 32);
    for (int j = 0; j < 32; j++) check("ones_byte", cap[j], 8'hFF);
    check("ones_ready_gap", max_low <= 1, 1);

    // Random data with a 5-cycle backpressure hold plus random stalls.
    sel = 0;
    fill_random();
    run_frame(-1, 100, 100, 100);
    fill_random();
    run_frame(-1, 60, 50, 150);

    // W=3 with out-of-range coefficients.
    sel = 1;
    fill_random();
    cq[5] = 7; cq[6] = 7; cq[200] = 7;
    run_frame(-1, 100, 100, -1);
    check("w3_b1_has_111", cap[1][7:7] & cap[2][1:0] == 2'b11, 1);
    fill_random();
    run_frame(-1, 70, 60, -1);

    // W=1 random with stalls.
    sel = 2;
    fill_random();
    run_frame(-1, 50, 50, -1);

    // Abort mid-polynomial, then a clean frame.
    sel = 0;
    fill_random();
    run_frame(100, 80, 80, -1);
    pulse_reset();
    fill_random();
    run_frame(-1, 90, 70, -1);
    check("post_abort_len", cap.size(), 320);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
